// File: rtl/time_pkg.sv
// time_pkg: shared definitions for the time-setting controller.
//   state_e  : controller state encoding, as seen on the mode output
//   MIN_LIM / HR_LIM : packed-BCD upper limits of the minutes and hours fields
//   bcd_inc  : packed-BCD increment with wrap at the limit; invalid input -> 00
package time_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_MIN = 2'b01,
    SET_HR  = 2'b10,
    BAD     = 2'b11   // never entered; recovers to RUN
  } state_e;

  localparam logic [7:0] MIN_LIM = 8'h59;
  localparam logic [7:0] HR_LIM  = 8'h23;

  // Valid BCD values keep their numeric order when compared as plain binary,
  // so one compare against the limit covers both "wrap" and "out of range".
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
    logic [7:0] r;
    if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v >= lim) r = 8'h00;
    else if (v[3:0] == 4'd9)                         r = {v[7:4] + 4'd1, 4'd0};
    else                                             r = {v[7:4], v[3:0] + 4'd1};
    return r;
  endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// time_set_ctrl_if: bundle between the controller and the clock datapath.
//   btn_mode, btn_inc         : raw buttons (async, active-high)
//   sec_q, min_q, hr_q        : current packed-BCD counter values
//   tick                      : one-cycle seconds pulse
//   sec_load/min_load/hr_load : one-cycle load strobes, data on load_data
//   mode                      : controller state (00 RUN, 01 SET_MIN, 10 SET_HR)
//   blink                     : display field-blink enable
// master = controller side, slave = datapath / board side.
interface time_set_ctrl_if;
  logic       btn_mode, btn_inc;
  logic [7:0] sec_q, min_q, hr_q;
  logic       tick;
  logic       sec_load, min_load, hr_load;
  logic [7:0] load_data;
  logic [1:0] mode;
  logic       blink;

  modport master (
    input  btn_mode, btn_inc, sec_q, min_q, hr_q,
    output tick, sec_load, min_load, hr_load, load_data, mode, blink
  );

  modport slave (
    output btn_mode, btn_inc, sec_q, min_q, hr_q,
    input  tick, sec_load, min_load, hr_load, load_data, mode, blink
  );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, level debouncer and press detector.
//   clk, reset : clock, synchronous active-high reset
//   btn        : raw asynchronous button
//   press      : one-cycle pulse when the debounced level rises
// The debounced level flips once DB_LEN consecutive synchronized samples
// disagree with it; any agreeing sample restarts the count.
module btn_debounce #(
  parameter int DB_LEN = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CW = (DB_LEN > 1) ? $clog2(DB_LEN) : 1;

  logic [1:0]    sync;
  logic          lvl;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync  <= '0;
      lvl   <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] == lvl) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_LEN - 1)) begin
        cnt   <= '0;
        lvl   <= sync[1];
        press <= sync[1];   // rising edge only; releases are silent
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: mode FSM, seconds prescaler and field-set logic of a clock.
//   clk, reset : clock, synchronous active-high reset
//   ifc        : time_set_ctrl_if.master (buttons, counter values, tick,
//                load strobes + load_data, mode, blink)
// Mode press cycles RUN -> SET_MIN -> SET_HR -> RUN. Entering SET_MIN clears
// seconds; inc presses in the set states load field+1 (BCD) one cycle later.
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int TICK_DIV = 1000,
  parameter int DB_LEN   = 16
) (
  input logic            clk,
  input logic            reset,
  time_set_ctrl_if.master ifc
);
  localparam int NBTN = 2;
  localparam int PW   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [NBTN-1:0] btn_raw, press;
  logic            mode_p, inc_p;

  assign btn_raw = {ifc.btn_inc, ifc.btn_mode};
  assign mode_p  = press[0];
  assign inc_p   = press[1];

  for (genvar i = 0; i < NBTN; i++) begin : g_db
    btn_debounce #(.DB_LEN(DB_LEN)) u_db (
      .clk   (clk),
      .reset (reset),
      .btn   (btn_raw[i]),
      .press (press[i])
    );
  end

  state_e          state, state_n;
  logic [PW-1:0]   pre, pre_n, bcnt, bcnt_n;
  logic            tick_q, tick_n, blink_q, blink_n;
  logic            sec_q_ld, sec_n, min_q_ld, min_n, hr_q_ld, hr_n;
  logic [7:0]      data_q, data_n;
  logic            in_set, set_n;

  // seconds value is part of the bus but never needed for control
  logic unused_sec;
  assign unused_sec = ^ifc.sec_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      pre      <= '0;
      bcnt     <= '0;
      tick_q   <= 1'b0;
      blink_q  <= 1'b0;
      sec_q_ld <= 1'b0;
      min_q_ld <= 1'b0;
      hr_q_ld  <= 1'b0;
      data_q   <= 8'h00;
    end else begin
      state    <= state_n;
      pre      <= pre_n;
      bcnt     <= bcnt_n;
      tick_q   <= tick_n;
      blink_q  <= blink_n;
      sec_q_ld <= sec_n;
      min_q_ld <= min_n;
      hr_q_ld  <= hr_n;
      data_q   <= data_n;
    end
  end

  always_comb begin
    state_n = state;
    pre_n   = '0;
    bcnt_n  = '0;
    blink_n = 1'b0;
    sec_n   = 1'b0;
    min_n   = 1'b0;
    hr_n    = 1'b0;
    data_n  = 8'h00;

    case (state)
      RUN:     if (mode_p) state_n = SET_MIN;
      SET_MIN: if (mode_p) state_n = SET_HR;
      SET_HR:  if (mode_p) state_n = RUN;
      default: state_n = RUN;
    endcase

    // Prescaler only advances while staying in RUN, so every entry to RUN
    // restarts the tick phase from zero. tick is registered alongside the
    // count and so is high exactly while the count sits at TICK_DIV-1.
    if (state == RUN && state_n == RUN)
      pre_n = (pre == LAST) ? '0 : pre + 1'b1;
    tick_n = (state_n == RUN) && (pre_n == LAST);

    // Blink runs continuously across SET_MIN -> SET_HR, cleared elsewhere.
    in_set = (state == SET_MIN) || (state == SET_HR);
    set_n  = (state_n == SET_MIN) || (state_n == SET_HR);
    if (in_set && set_n) begin
      bcnt_n  = (bcnt == LAST) ? '0 : bcnt + 1'b1;
      blink_n = (bcnt == LAST) ? ~blink_q : blink_q;
    end

    // A mode press masks a coincident inc press.
    sec_n = (state == RUN)     && mode_p;
    min_n = (state == SET_MIN) && inc_p && !mode_p;
    hr_n  = (state == SET_HR)  && inc_p && !mode_p;
    if (min_n)     data_n = bcd_inc(ifc.min_q, MIN_LIM);
    else if (hr_n) data_n = bcd_inc(ifc.hr_q, HR_LIM);
  end

  assign ifc.tick      = tick_q;
  assign ifc.blink     = blink_q;
  assign ifc.sec_load  = sec_q_ld;
  assign ifc.min_load  = min_q_ld;
  assign ifc.hr_load   = hr_q_ld;
  assign ifc.load_data = data_q;
  assign ifc.mode      = state;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: scenario tasks with randomized bounce and field values,
// expected results from a decimal-arithmetic model of the set rules.
module tb_time_set_ctrl;
  localparam int TD = 4;
  localparam int DB = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  time_set_ctrl_if ifc();

  time_set_ctrl #(.TICK_DIV(TD), .DB_LEN(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .ifc   (ifc)
  );

  int vectors = 0;
  int miscompares = 0;

  // event counters maintained by the monitor (1 time unit after each edge)
  int n_tick = 0, n_sec = 0, n_min = 0, n_hr = 0, n_viol = 0;
  logic [7:0] last_data = 8'h00;

  initial forever begin
    @(posedge clk);
    #1;
    if (ifc.tick === 1'b1) n_tick++;
    if (ifc.sec_load === 1'b1) begin n_sec++; last_data = ifc.load_data; end
    if (ifc.min_load === 1'b1) begin n_min++; last_data = ifc.load_data; end
    if (ifc.hr_load  === 1'b1) begin n_hr++;  last_data = ifc.load_data; end
    if (reset === 1'b0) begin
      if (int'(ifc.sec_load) + int'(ifc.min_load) + int'(ifc.hr_load) > 1) n_viol++;
      if (!(ifc.sec_load | ifc.min_load | ifc.hr_load) && ifc.load_data !== 8'h00) n_viol++;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // decimal model of a field increment with wrap at lim
  function automatic logic [7:0] ref_inc(input logic [7:0] v, input int lim);
    int hi, lo, d;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9) return 8'h00;
    d = hi * 10 + lo;
    if (d > lim) return 8'h00;
    d = (d + 1) % (lim + 1);
    return 8'((d / 10) * 16 + (d % 10));
  endfunction

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #3; end
  endtask

  task automatic wait_mode(input logic [1:0] m, input int budget, output int k);
    k = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (ifc.mode === m) begin k = i; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(2);
    vectors++; if (ifc.mode !== 2'b00) begin miscompares++; $display("FAIL reset_mode: got %b want 00", ifc.mode); end
    vectors++; if (ifc.tick !== 1'b0) begin miscompares++; $display("FAIL reset_tick: got %b want 0", ifc.tick); end
    vectors++; if ({ifc.sec_load, ifc.min_load, ifc.hr_load} !== 3'b000) begin miscompares++;
      $display("FAIL reset_loads: got %b want 000", {ifc.sec_load, ifc.min_load, ifc.hr_load}); end
    vectors++; if (ifc.load_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", ifc.load_data); end
    vectors++; if (ifc.blink !== 1'b0) begin miscompares++; $display("FAIL reset_blink: got %b want 0", ifc.blink); end
  endtask

  task automatic test_run_tick();
    int t0, l0;
    t0 = n_tick; l0 = n_sec + n_min + n_hr;
    reset = 1'b0;
    for (int j = 1; j <= 20; j++) begin
      step();
      vectors++;
      if (ifc.tick !== ((j % TD) == TD - 1)) begin miscompares++;
        $display("FAIL run_tick cycle %0d: got %b want %b", j, ifc.tick, (j % TD) == TD - 1); end
    end
    vectors++; if (n_tick - t0 != 5) begin miscompares++; $display("FAIL run_tick_count: got %0d want 5", n_tick - t0); end
    vectors++; if (n_sec + n_min + n_hr - l0 != 0) begin miscompares++; $display("FAIL run_no_loads: got %0d want 0", n_sec + n_min + n_hr - l0); end
    vectors++; if (ifc.blink !== 1'b0) begin miscompares++; $display("FAIL run_blink: got %b want 0", ifc.blink); end
  endtask

  task automatic test_mode_bounce();
    int len, k, s0, m0;
    s0 = n_sec; m0 = n_min + n_hr;
    len = $urandom_range(15, 4);
    for (int i = 0; i < len; i++) begin
      ifc.btn_mode = 1'($urandom_range(0, 1));
      step();
    end
    ifc.btn_mode = 1'b1;
    wait_mode(2'b01, 60, k);
    vectors++; if (k < 0) begin miscompares++; $display("FAIL bounce_enter_setmin: mode %b after timeout, want 01", ifc.mode); end
    vectors++; if (ifc.sec_load !== 1'b1 || ifc.load_data !== 8'h00) begin miscompares++;
      $display("FAIL bounce_sec_load: got load=%b data=%h want 1/00", ifc.sec_load, ifc.load_data); end
    for (int c = 0; c < 12; c++) begin
      vectors++;
      if (ifc.blink !== (((c / TD) % 2) == 1)) begin miscompares++;
        $display("FAIL setmin_blink cycle %0d: got %b want %b", c, ifc.blink, ((c / TD) % 2) == 1); end
      step();
    end
    step(20);
    ifc.btn_mode = 1'b0;
    step(30);
    vectors++; if (ifc.mode !== 2'b01) begin miscompares++; $display("FAIL bounce_single_press: mode %b want 01", ifc.mode); end
    vectors++; if (n_sec - s0 != 1) begin miscompares++; $display("FAIL bounce_sec_cycles: got %0d want 1", n_sec - s0); end
    vectors++; if (n_min + n_hr - m0 != 0) begin miscompares++; $display("FAIL bounce_other_loads: got %0d want 0", n_min + n_hr - m0); end
  endtask

  // one inc press in the current set state; checks the strobe and its data
  task automatic test_field_inc(input bit is_hr, input logic [7:0] v);
    int s_tgt, s_oth, found, lim;
    logic [7:0] exp;
    lim = is_hr ? 23 : 59;
    if (is_hr) begin ifc.hr_q = v; ifc.min_q = 8'($urandom); end
    else       begin ifc.min_q = v; ifc.hr_q = 8'($urandom); end
    ifc.sec_q = 8'($urandom);
    exp   = ref_inc(v, lim);
    s_tgt = is_hr ? n_hr : n_min;
    s_oth = n_sec + (is_hr ? n_min : n_hr);
    ifc.btn_inc = 1'b1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if ((is_hr ? n_hr : n_min) != s_tgt) begin found = 1; break; end
    end
    vectors++; if (found == 0) begin miscompares++; $display("FAIL inc_strobe %s %h: no load within budget", is_hr ? "hr" : "min", v); end
    vectors++; if (last_data !== exp) begin miscompares++;
      $display("FAIL inc_data %s %h: got %h want %h", is_hr ? "hr" : "min", v, last_data, exp); end
    ifc.btn_inc = 1'b0;
    step(30);
    vectors++; if ((is_hr ? n_hr : n_min) - s_tgt != 1) begin miscompares++;
      $display("FAIL inc_once %s %h: got %0d strobes want 1", is_hr ? "hr" : "min", v, (is_hr ? n_hr : n_min) - s_tgt); end
    vectors++; if (n_sec + (is_hr ? n_min : n_hr) - s_oth != 0) begin miscompares++;
      $display("FAIL inc_other %s %h: got %0d stray strobes", is_hr ? "hr" : "min", v, n_sec + (is_hr ? n_min : n_hr) - s_oth); end
  endtask

  task automatic test_min_inc();
    logic [7:0] vals [6] = '{8'h59, 8'h09, 8'h00, 8'h58, 8'h5A, 8'h60};
    foreach (vals[i]) test_field_inc(1'b0, vals[i]);
    for (int i = 0; i < 4; i++) test_field_inc(1'b0, 8'($urandom));
  endtask

  task automatic test_same_cycle();
    int k, s0;
    s0 = n_sec + n_min + n_hr;
    ifc.btn_mode = 1'b1;
    ifc.btn_inc  = 1'b1;
    wait_mode(2'b10, 60, k);
    vectors++; if (k < 0) begin miscompares++; $display("FAIL same_cycle_mode: mode %b want 10", ifc.mode); end
    step(5);
    ifc.btn_mode = 1'b0;
    ifc.btn_inc  = 1'b0;
    step(30);
    vectors++; if (ifc.mode !== 2'b10) begin miscompares++; $display("FAIL same_cycle_hold: mode %b want 10", ifc.mode); end
    vectors++; if (n_sec + n_min + n_hr - s0 != 0) begin miscompares++; $display("FAIL same_cycle_loads: got %0d want 0", n_sec + n_min + n_hr - s0); end
  endtask

  task automatic test_hr_inc();
    logic [7:0] vals [6] = '{8'h23, 8'h1A, 8'h09, 8'h19, 8'h22, 8'h24};
    foreach (vals[i]) test_field_inc(1'b1, vals[i]);
    for (int i = 0; i < 4; i++) test_field_inc(1'b1, 8'($urandom));
  endtask

  task automatic test_return_run();
    int k, s0;
    ifc.btn_mode = 1'b1;
    wait_mode(2'b00, 60, k);
    vectors++; if (k < 0) begin miscompares++; $display("FAIL return_run_mode: mode %b want 00", ifc.mode); end
    for (int c = 0; c < 12; c++) begin
      vectors++;
      if (ifc.tick !== ((c % TD) == TD - 1)) begin miscompares++;
        $display("FAIL return_run_tick cycle %0d: got %b want %b", c, ifc.tick, (c % TD) == TD - 1); end
      vectors++; if (ifc.blink !== 1'b0) begin miscompares++; $display("FAIL return_run_blink cycle %0d: got %b want 0", c, ifc.blink); end
      step();
    end
    ifc.btn_mode = 1'b0;
    step(30);
    s0 = n_sec + n_min + n_hr;
    ifc.min_q = 8'h12; ifc.hr_q = 8'h05;
    ifc.btn_inc = 1'b1;
    step(40);
    ifc.btn_inc = 1'b0;
    step(30);
    vectors++; if (n_sec + n_min + n_hr - s0 != 0) begin miscompares++; $display("FAIL run_inc_ignored: got %0d strobes want 0", n_sec + n_min + n_hr - s0); end
    vectors++; if (ifc.mode !== 2'b00) begin miscompares++; $display("FAIL run_inc_mode: mode %b want 00", ifc.mode); end
  endtask

  task automatic test_reset_mid();
    int k, s0;
    for (int p = 0; p < 2; p++) begin
      ifc.btn_mode = 1'b1;
      wait_mode(2'(p + 1), 60, k);
      vectors++; if (k < 0) begin miscompares++; $display("FAIL mid_enter %0d: mode %b", p + 1, ifc.mode); end
      ifc.btn_mode = 1'b0;
      step(30);
    end
    s0 = n_sec + n_min + n_hr;
    ifc.hr_q = 8'h07;
    ifc.btn_inc = 1'b1;
    step(10);
    reset = 1'b1;
    ifc.btn_inc = 1'b0;
    step(2);
    vectors++; if ({ifc.mode, ifc.tick, ifc.blink, ifc.sec_load, ifc.min_load, ifc.hr_load, ifc.load_data} !== 15'd0) begin miscompares++;
      $display("FAIL mid_reset_outputs: mode=%b tick=%b blink=%b loads=%b data=%h want all 0",
               ifc.mode, ifc.tick, ifc.blink, {ifc.sec_load, ifc.min_load, ifc.hr_load}, ifc.load_data); end
    reset = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      step();
      vectors++;
      if (ifc.tick !== ((j % TD) == TD - 1)) begin miscompares++;
        $display("FAIL mid_reset_tick cycle %0d: got %b want %b", j, ifc.tick, (j % TD) == TD - 1); end
    end
    step(30);
    vectors++; if (n_sec + n_min + n_hr - s0 != 0) begin miscompares++; $display("FAIL mid_reset_strobes: got %0d want 0", n_sec + n_min + n_hr - s0); end
    vectors++; if (ifc.mode !== 2'b00) begin miscompares++; $display("FAIL mid_reset_mode: mode %b want 00", ifc.mode); end
  endtask

  task automatic test_invariants();
    vectors++; if (n_viol != 0) begin miscompares++; $display("FAIL strobe_invariants: %0d violating cycles, want 0", n_viol); end
  endtask

  initial begin
    reset = 1'b1;
    ifc.btn_mode = 1'b0;
    ifc.btn_inc  = 1'b0;
    ifc.sec_q = 8'h00;
    ifc.min_q = 8'h00;
    ifc.hr_q  = 8'h00;
    step(3);
    test_reset();
    test_run_tick();
    test_mode_bounce();
    test_min_inc();
    test_same_cycle();
    test_hr_inc();
    test_return_run();
    test_reset_mid();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 1000: clk cycles per seconds tick; legal range is 2 or more.
REQ-002 Parameter DB_LEN, default 16: consecutive stable synchronized samples needed to accept a button level change.
REQ-003 clk  in  1  sole clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 btn_mode  in  1  raw mode button, asynchronous, active-high.
REQ-006 btn_inc  in  1  raw increment button, asynchronous, active-high.
REQ-007 sec_q / min_q / hr_q  in  8 each  current packed-BCD value of the seconds, minutes and hours counters.
REQ-008 tick  out  1  one-cycle cin pulse to the seconds counter.
REQ-009 sec_load / min_load / hr_load  out  1 each  one-cycle load strobe for the matching counter.
REQ-010 load_data  out  8  packed-BCD value shared by all load strobes.
REQ-011 mode  out  2  current state: 00 RUN, 01 SET_MIN, 10 SET_HR.
REQ-012 blink  out  1  field-blink enable for the display.

Function
REQ-013 Each button passes through a 2-FF synchronizer, then a debounce counter; the debounced level changes only after DB_LEN consecutive synchronized samples differ from it.
REQ-014 A press is a one-cycle pulse on the debounced 0->1 edge; releases produce no event.
REQ-015 Prescaler counts 0..TICK_DIV-1 in RUN; tick=1 in the cycle the count equals TICK_DIV-1, then the count wraps to 0.
REQ-016 In SET_MIN and SET_HR the prescaler holds at 0 and tick stays 0.
REQ-017 State transitions on mode press: RUN->SET_MIN, SET_MIN->SET_HR, SET_HR->RUN; encoding 11 is unreachable and recovers to RUN on the next cycle.
REQ-018 On entry to SET_MIN: sec_load=1 with load_data=8'h00 for exactly one cycle.
REQ-019 inc press in SET_MIN: one cycle after the press pulse, min_load=1 with load_data = BCD(min_q+1); 8'h59 wraps to 8'h00.
REQ-020 inc press in SET_HR: one cycle after the press pulse, hr_load=1 with load_data = BCD(hr_q+1); 8'h23 wraps to 8'h00.
REQ-021 BCD increment: low nibble 9 -> 0 with carry into the high nibble, otherwise +1.
REQ-022 An input field with an invalid BCD digit (either nibble >9) or value above its limit loads 8'h00.
REQ-023 inc press in RUN is ignored.
REQ-024 If mode and inc presses fall in the same cycle, the mode press wins and the inc press is discarded.
REQ-025 At most one load strobe is high in any cycle; load_data=8'h00 whenever no strobe is high.
REQ-026 blink toggles every TICK_DIV cycles in the set states from a separate blink counter; blink=0 in RUN.
REQ-027 On the SET_HR->RUN transition the prescaler restarts at 0, so the first tick arrives TICK_DIV cycles later.
REQ-028 All outputs are registered.

Reset
REQ-029 While reset=1 on a clock edge: state=RUN, prescaler=0, blink counter=0, synchronizers, debounce counters and debounced levels=0.
REQ-030 While reset=1 on a clock edge: tick, all load strobes and blink=0; load_data=8'h00; mode=00.
REQ-031 Reset asserted mid-debounce or mid-edit discards pending presses and suppresses all load strobes.

Structure
REQ-032 Package time_pkg holds the state encodings, BCD limits 8'h59 and 8'h23, and the BCD increment/validate function.
REQ-033 Sub-module btn_debounce (synchronizer, counter, edge pulse; DB_LEN parameter) is instantiated twice.

Verification
REQ-034 TICK_DIV=4, reset released, RUN held for 20 cycles -> tick high every 4th cycle, 5 pulses total, no load strobes.
REQ-035 btn_mode bounced 0/1 for fewer than 16 cycles then held high -> exactly one mode press; mode=01; sec_load=1 with data 00 for 1 cycle.
REQ-036 SET_MIN, min_q=8'h59, inc press -> min_load=1, load_data=8'h00 one cycle after the press pulse; min_q=8'h09 -> 8'h10.
REQ-037 SET_HR, hr_q=8'h23, inc press -> hr_load=1, load_data=8'h00; hr_q=8'h1A (invalid) -> 8'h00.
REQ-038 mode and inc presses in the same cycle while in SET_MIN -> mode=10, no min_load.
REQ-039 reset pulsed in SET_HR with inc debouncing -> mode=00 and no strobes; first tick arrives TICK_DIV cycles after reset deasserts.
